shreg_cmd_sequencer: RTL and testbench
======================================

// Module: shreg_cmd_sequencer
// PURPOSE
//  Command-driven controller for the 8-bit negedge multi-function shift register.
//  Accepts one command (op, repeat count, load data, serial bits) over a valid/ready handshake.
//  Drives the register's sel/inp/D for exactly N operations, then returns it to HOLD.
//  The register has no hold code, so HOLD = LOAD (sel=001) with D fed back from Q.
//  Sits beside the register in the parent; register Q returns on q_in.
// PARAMETERS
//  DATA_W  8   register width; only 8 is legal.
//  CNT_W   4   repeat-count width; max ops per command = 2**CNT_W-1 (15).
//  SER_W   16  serial-bit buffer width = 2**CNT_W; derived, do not override.
// PORTS
//  clk        in   1       single clock; rising edge for this block, register samples on falling edge
//  rst_n      in   1       asynchronous, active-low reset
//  cmd_valid  in   1       command offered
//  cmd_ready  out  1       block can accept (=state IDLE, combinational)
//  cmd_op     in   3       op code, same encoding as register sel
//  cmd_cnt    in   CNT_W   number of register operations to perform
//  cmd_data   in   DATA_W  parallel load value (used by op 001)
//  cmd_ser    in   SER_W   serial-in bits for op 101, consumed LSB first, one per op
//  q_in       in   DATA_W  register Q feedback
//  sel        out  3       to register sel (registered)
//  inp        out  1       to register inp (registered)
//  d          out  DATA_W  to register D: hold ? q_in : data_r (combinational mux)
//  busy       out  1       RUN in progress (registered)
//  done       out  1       one-cycle pulse when a command completes (registered)
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, sel=3'b001, inp=0, hold=1, busy=0, done=0; register contents untouched.
//  States: IDLE, RUN. Cycle k = posedge k .. posedge k+1; register acts on the negedge within the cycle.
//  IDLE: hold=1, sel=001, d=q_in. Accept when cmd_valid&cmd_ready at posedge k.
//  Capture op_r, data_r, ser_r, rem=cmd_cnt. Ops 000 and 001 force rem=1.
//  Accept with rem>=1: from posedge k, sel=op_r, inp=cmd_ser[0], hold=0, busy=1; state RUN.
//  RUN: each posedge with rem>1: rem--, ser_r>>=1, inp=next bit. Register performs op on every negedge.
//  Completion: N ops occur on negedges of cycles k..k+N-1.
//  At posedge k+N: sel=001, hold=1, busy=0, done=1 for one cycle; state IDLE.
//  Next accept is at posedge k+N+1 at the earliest, leaving one guaranteed hold cycle.
//  cmd_cnt=0 (ops other than 000/001): no register op; stay IDLE, hold, done=1 in cycle k only.
//  cmd_valid while busy: ignored (ready=0); the command must be held by the source until accepted.
//  inp is only meaningful for op 101; it is driven from ser_r for all ops.
//  Reset mid-RUN: outputs go to hold immediately (async); no done pulse; register keeps its current Q.
//  cmd_op/cmd_data changes after accept have no effect.
// STRUCTURE
//  Shared package shreg_pkg: OP_CLR=000, OP_LOAD=001, OP_SRL=010, OP_SLL=011, OP_SRA=100,
//  OP_SIN=101, OP_ROR=110, OP_ROL=111, OP_HOLD=OP_LOAD, state enum {IDLE,RUN}.
//  No sub-module inside; the register is instantiated next to this block in the parent.
//  The bench instantiates both, with sel/inp/d/q_in wired.
// TESTING
//  1 Reset, then idle 5 cycles with Q preloaded 8'hA5 -> Q stays 8'hA5; sel=001, d=8'hA5 every cycle.
//  2 LOAD data=8'h81, then ROL cnt=3 -> Q=8'h0C; busy high exactly 3 cycles; single done pulse; Q then holds.
//  3 LOAD 8'h80, SRA cnt=2 -> Q=8'hE0. LOAD 8'h01, SLL cnt=7 -> 8'h80; SRL cnt=15 -> 8'h00.
//  4 LOAD 8'h00, SIN cnt=8 ser=16'h00A5 -> Q=8'hA5; inp sequence 1,0,1,0,0,1,0,1.
//  5 SLL with cnt=0 -> done in accept cycle, busy never high, Q unchanged; cmd_valid while busy -> not accepted.
//  6 rst_n low at cycle 2 of ROR cnt=10 on Q=8'h01 -> sel=001 same cycle; Q frozen at 8'h40; no done; ready=1 after release.

Source files
------------

// File: rtl/shreg_pkg.sv
// Shared op codes and sequencer state for the negedge multi-function shift register.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package shreg_pkg;

    // Op codes are the register's own sel encoding.
    localparam logic [2:0] OP_CLR  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_SLL  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
    localparam logic [2:0] OP_SIN  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_ROL  = 3'b111;

    // The register has no hold code: hold is a load of its own Q.
    localparam logic [2:0] OP_HOLD = OP_LOAD;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Clear and load are idempotent, so they always execute exactly once.
    function automatic logic is_single_shot(input logic [2:0] op);
        return (op == OP_CLR) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/shreg_reg.sv
// 8-bit multi-function shift register acting on the falling clock edge; no reset, contents survive controller reset.
// Latency: Q updates at the negedge following a sel/inp/d change.
// Backpressure: none; performs the selected op every negedge.
module shreg_reg
    import shreg_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic [2:0]        sel,
    input  logic              inp,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // One register op per falling edge; SIN shifts right with inp entering at the MSB.
    always_ff @(negedge clk) begin
        case (sel)
            OP_CLR:  q <= '0;
            OP_LOAD: q <= d;
            OP_SRL:  q <= {1'b0, q[DATA_W-1:1]};
            OP_SLL:  q <= {q[DATA_W-2:0], 1'b0};
            OP_SRA:  q <= {q[DATA_W-1], q[DATA_W-1:1]};
            OP_SIN:  q <= {inp, q[DATA_W-1:1]};
            OP_ROR:  q <= {q[0], q[DATA_W-1:1]};
            default: q <= {q[DATA_W-2:0], q[DATA_W-1]};
        endcase
    end

endmodule

// File: rtl/shreg_cmd_sequencer.sv
// Command sequencer: drives the shift register through N ops of one op code, then parks it in hold (load of own Q).
// Latency: register ops on negedges of cycles k..k+N-1 after accept at posedge k; done pulses in cycle k+N.
// Backpressure: cmd_ready low while a command runs; source holds cmd_* until accepted.
module shreg_cmd_sequencer
    import shreg_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4,
    parameter int SER_W  = 2**CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [CNT_W-1:0]  cmd_cnt,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [SER_W-1:0]  cmd_ser,
    input  logic [DATA_W-1:0] q_in,
    output logic [2:0]        sel,
    output logic              inp,
    output logic [DATA_W-1:0] d,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state, nxt_state;
    logic [CNT_W-1:0]  rem, nxt_rem;
    logic [SER_W-1:0]  ser_r, nxt_ser;
    logic [DATA_W-1:0] data_r, nxt_data;
    logic              hold, nxt_hold;
    logic [2:0]        nxt_sel;
    logic              nxt_inp;
    logic              nxt_busy;
    logic              nxt_done;
    logic [CNT_W-1:0]  cnt_eff;

    assign cmd_ready = (state == IDLE);
    assign cnt_eff   = is_single_shot(cmd_op) ? CNT_ONE : cmd_cnt;

    // While holding, the register reloads its own Q; otherwise it sees the captured load value.
    assign d = hold ? q_in : data_r;

    // State and registered outputs; reset parks the register in hold without touching its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rem    <= '0;
            ser_r  <= '0;
            data_r <= '0;
            hold   <= 1'b1;
            sel    <= OP_HOLD;
            inp    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= nxt_state;
            rem    <= nxt_rem;
            ser_r  <= nxt_ser;
            data_r <= nxt_data;
            hold   <= nxt_hold;
            sel    <= nxt_sel;
            inp    <= nxt_inp;
            busy   <= nxt_busy;
            done   <= nxt_done;
        end
    end

    // Next-state: accept in IDLE, count ops down in RUN, return to hold after the last one.
    always_comb begin
        nxt_state = state;
        nxt_rem   = rem;
        nxt_ser   = ser_r;
        nxt_data  = data_r;
        nxt_hold  = hold;
        nxt_sel   = sel;
        nxt_inp   = inp;
        nxt_busy  = busy;
        nxt_done  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    nxt_data = cmd_data;
                    if (cnt_eff == '0) begin
                        // Zero-length command: nothing to do, report completion right away.
                        nxt_done = 1'b1;
                    end else begin
                        // ser_r keeps only the bits still to come; bit 0 goes out now.
                        nxt_rem   = cnt_eff;
                        nxt_ser   = cmd_ser >> 1;
                        nxt_inp   = cmd_ser[0];
                        nxt_sel   = cmd_op;
                        nxt_hold  = 1'b0;
                        nxt_busy  = 1'b1;
                        nxt_state = RUN;
                    end
                end
            end
            RUN: begin
                if (rem > CNT_ONE) begin
                    nxt_rem = rem - CNT_ONE;
                    nxt_inp = ser_r[0];
                    nxt_ser = ser_r >> 1;
                end else begin
                    nxt_sel   = OP_HOLD;
                    nxt_inp   = 1'b0;
                    nxt_hold  = 1'b1;
                    nxt_busy  = 1'b0;
                    nxt_done  = 1'b1;
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shreg_cmd_sequencer.sv
// Bench for shreg_cmd_sequencer driving a shreg_reg, with a done-driven scoreboard.
// Latency: n/a.
// Backpressure: stimulus holds each command until cmd_ready.
module tb_shreg_cmd_sequencer;
    import shreg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = OP_LOAD;
    logic [3:0]  cmd_cnt = '0;
    logic [7:0]  cmd_data = '0;
    logic [15:0] cmd_ser = '0;
    logic [7:0]  q_in;
    logic [2:0]  sel;
    logic        inp;
    logic [7:0]  d;
    logic        busy;
    logic        done;
    logic        preload = 1'b0;
    logic [7:0]  reg_d;
    logic [7:0]  q;

    always #5 clk = ~clk;

    shreg_cmd_sequencer #(.DATA_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_ser(cmd_ser),
        .q_in(q_in), .sel(sel), .inp(inp), .d(d), .busy(busy), .done(done)
    );

    // Bench-side mux lets reset load a known Q into the reset-less register.
    assign reg_d = preload ? 8'hA5 : d;
    assign q_in  = q;

    shreg_reg #(.DATA_W(8)) u_reg (.clk(clk), .sel(sel), .inp(inp), .d(reg_d), .q(q));

    typedef struct {
        logic [7:0] q;
        int         busy;
    } exp_t;

    exp_t sb[$];
    logic inp_log[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse pops one expectation (final Q and busy length).
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                busy_cnt = 0;
            end else begin
                if (busy) begin
                    busy_cnt++;
                    if (sel == OP_SIN) inp_log.push_back(inp);
                end
                if (done) begin
                    check("done_expected", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("done_q", 32'(q), 32'(e.q));
                        check("busy_cycles", busy_cnt, e.busy);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        int b = 0;
        while (!cmd_ready && b < 200) begin
            @(posedge clk);
            #2;
            b++;
        end
        if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 1);
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] cnt, input logic [7:0] data,
                        input logic [15:0] ser, input logic [7:0] eq, input int eb);
        cmd_op   = op;
        cmd_cnt  = cnt;
        cmd_data = data;
        cmd_ser  = ser;
        cmd_valid = 1'b1;
        sb.push_back('{q: eq, busy: eb});
        wait_ready();
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        cmd_op    = OP_CLR;
        cmd_data  = 8'hFF;
    endtask

    task automatic run(input logic [2:0] op, input logic [3:0] cnt, input logic [7:0] data,
                       input logic [15:0] ser, input logic [7:0] eq, input int eb);
        send(op, cnt, data, ser, eq, eb);
        wait_ready();
        @(posedge clk);
        #2;
    endtask

    logic exp_inp [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        // 1: reset outputs, Q preloaded and held while idle
        #1 rst_n = 1'b0;
        preload = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_sel", 32'(sel), 32'(OP_HOLD));
        check("rst_inp", 32'(inp), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ready", 32'(cmd_ready), 1);
        preload = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            check("idle_q", 32'(q), 32'hA5);
            check("idle_sel", 32'(sel), 32'(OP_HOLD));
            check("idle_d", 32'(d), 32'hA5);
        end

        // 2: LOAD (cnt 0 still loads once), ROL x3, then Q holds
        run(OP_LOAD, 4'd0, 8'h81, 16'h0, 8'h81, 1);
        run(OP_ROL, 4'd3, 8'h00, 16'h0, 8'h0C, 3);
        repeat (3) @(posedge clk);
        #2;
        check("hold_after_rol", 32'(q), 32'h0C);

        // 3: arithmetic and logical shifts, max count
        run(OP_LOAD, 4'd5, 8'h80, 16'h0, 8'h80, 1);
        run(OP_SRA, 4'd2, 8'h00, 16'h0, 8'hE0, 2);
        run(OP_LOAD, 4'd1, 8'h01, 16'h0, 8'h01, 1);
        run(OP_SLL, 4'd7, 8'h00, 16'h0, 8'h80, 7);
        run(OP_SRL, 4'd15, 8'h00, 16'h0, 8'h00, 15);

        // 4: serial-in, bits consumed LSB first
        run(OP_LOAD, 4'd1, 8'h00, 16'h0, 8'h00, 1);
        inp_log.delete();
        run(OP_SIN, 4'd8, 8'h00, 16'h00A5, 8'hA5, 8);
        check("sin_len", inp_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < inp_log.size()) check("sin_inp", 32'(inp_log[i]), 32'(exp_inp[i]));
        end

        // 5: zero-count shift is a no-op; a command offered while busy waits
        run(OP_SLL, 4'd0, 8'h00, 16'h0, 8'hA5, 0);
        check("cnt0_q", 32'(q), 32'hA5);
        send(OP_ROL, 4'd4, 8'h00, 16'h0, 8'h5A, 4);
        cmd_op    = OP_CLR;
        cmd_cnt   = 4'd1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("ready_while_busy", 32'(cmd_ready), 0);
            @(posedge clk);
            #2;
        end
        run(OP_CLR, 4'd1, 8'h00, 16'h0, 8'h00, 1);

        // 6: reset in cycle 2 of ROR x10 freezes Q at 0x40 with no done
        run(OP_LOAD, 4'd1, 8'h01, 16'h0, 8'h01, 1);
        cmd_op    = OP_ROR;
        cmd_cnt   = 4'd10;
        cmd_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_sel", 32'(sel), 32'(OP_HOLD));
        check("abort_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            check("abort_q", 32'(q), 32'h40);
            check("abort_done", 32'(done), 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("ready_after_release", 32'(cmd_ready), 1);
        check("q_after_release", 32'(q), 32'h40);
        repeat (3) @(posedge clk);
        #2;
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
